// File: rtl/mul_div_unit_if.sv
// Operand/request and register-file write port bundle for mul_div_unit.
// Latency: none (wires only).
// Backpressure: none; the requester watches busy and holds off start.
interface mul_div_unit_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  operand_a;
    logic [WIDTH-1:0]  operand_b;
    logic [ADDR_W-1:0] dest_address;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_address;
    logic [WIDTH-1:0]  wr_data;

    // Requester side (control unit / register-file reader and writer)
    modport master (
        output start, op, operand_a, operand_b, dest_address,
        input  busy, wr_en, wr_address, wr_data
    );

    // Execution unit side
    modport slave (
        input  start, op, operand_a, operand_b, dest_address,
        output busy, wr_en, wr_address, wr_data
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU with a one-cycle register-file write pulse.
// Latency: 33 cycles from acceptance to wr_en (1 cycle for zero operands with MUL_DIV_ZERO_BYPASS_EN).
// Backpressure: start is accepted only in IDLE; start while busy is dropped, never queued.
module mul_div_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  mdu
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int              CNT_W    = 6;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [ADDR_W-1:0] dest_q;
    // acc_q holds the product high word or the partial remainder;
    // lo_q holds the product low word/multiplier or the quotient/dividend.
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  lo_q;
    logic [WIDTH-1:0]  wr_data_q;
    logic [ADDR_W-1:0] wr_address_q;

    logic              busy;
    logic              wr_en;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi_n, mul_lo_n;
    // Shifted remainder is WIDTH+1 bits wide; the stored remainder always
    // fits WIDTH bits because it ends every step below the divisor.
    logic [WIDTH:0]    rem_sh;
    logic              div_ok;
    logic [WIDTH-1:0]  div_rem_n, div_quo_n;
    logic [WIDTH-1:0]  acc_n, lo_n, result_n;

    logic              byp_hit;
    logic [WIDTH-1:0]  byp_data;

    // One shift-add or restoring-divide step, plus the result picked from it
    always_comb begin
        mul_sum   = lo_q[0] ? ({1'b0, acc_q} + {1'b0, a_q}) : {1'b0, acc_q};
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};

        rem_sh    = {acc_q, lo_q[WIDTH-1]};
        div_ok    = (rem_sh >= {1'b0, b_q});
        div_rem_n = div_ok ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
        div_quo_n = {lo_q[WIDTH-2:0], div_ok};

        acc_n     = op_q[1] ? div_rem_n : mul_hi_n;
        lo_n      = op_q[1] ? div_quo_n : mul_lo_n;
        // MULHU and REMU (op[0]=1) take the high/remainder half
        result_n  = op_q[0] ? acc_n : lo_n;
    end

`ifdef MUL_DIV_ZERO_BYPASS_EN
    // Detect operands whose result is known without iterating
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (mdu.start) begin
            if (mdu.op[1]) begin
                byp_hit = (mdu.operand_b == '0);
            end else begin
                byp_hit = (mdu.operand_a == '0) || (mdu.operand_b == '0);
            end
        end
        case (mdu.op)
            2'b10:   byp_data = '1;
            2'b11:   byp_data = mdu.operand_a;
            default: byp_data = '0;
        endcase
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_data = '0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    state_d = byp_hit ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy covers RUN and DONE, write strobe only in DONE
    always_comb begin
        busy  = 1'b0;
        wr_en = 1'b0;
        case (state_q)
            S_RUN:   busy = 1'b1;
            S_DONE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture, iteration datapath and result/address holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            dest_q       <= '0;
            acc_q        <= '0;
            lo_q         <= '0;
            wr_data_q    <= '0;
            wr_address_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mdu.start) begin
                        op_q   <= mdu.op;
                        a_q    <= mdu.operand_a;
                        b_q    <= mdu.operand_b;
                        dest_q <= mdu.dest_address;
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        lo_q   <= mdu.op[1] ? mdu.operand_a : mdu.operand_b;
                        if (byp_hit) begin
                            wr_data_q    <= byp_data;
                            wr_address_q <= mdu.dest_address;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Result registers only move on entry to DONE so they
                    // hold the previous write everywhere else.
                    if (cnt_q == LAST_CNT) begin
                        wr_data_q    <= result_n;
                        wr_address_q <= dest_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mdu.busy       = busy;
    assign mdu.wr_en      = wr_en;
    assign mdu.wr_address = wr_address_q;
    assign mdu.wr_data    = wr_data_q;

endmodule
